pixel_frame_loader: RTL and testbench
=====================================

Name: pixel_frame_loader

Overview:
- Upstream feeder for the rate-coding input processor: accepts a serial pixel stream over a valid/ready handshake and assembles whole frames.
- Double-buffered. One frame fills a shadow buffer while the previous frame is held on the parallel pixel_value bus for a fixed number of spike timesteps.
- Gaps between frames present all-zero pixels, so the downstream stage emits no spikes during a gap.

Parameters:
INPUT_SIZE, 784, pixels per frame (matches network_pkg)
PIXEL_WIDTH, 8, bits per pixel
NUM_TIMESTEPS, 16, step_tick pulses each frame is presented for (>=1)
IDX_W, $clog2(INPUT_SIZE), derived pixel index width
STEP_W, $clog2(NUM_TIMESTEPS+1), derived step counter width

Ports:
clk  in  1  system clock; everything on posedge
rst  in  1  synchronous reset, active-high
s_valid  in  1  input pixel valid
s_ready  out  1  loader can accept a pixel
s_data  in  PIXEL_WIDTH  pixel value
s_last  in  1  marks the final pixel of a frame
step_tick  in  1  one-cycle strobe per spike timestep (clk-domain pulse)
pixel_value  out  PIXEL_WIDTH x [INPUT_SIZE]  active frame to input processor
frame_valid  out  1  pixel_value holds a live frame
step_idx  out  STEP_W  timesteps completed for the active frame
frame_done  out  1  one-cycle pulse: active frame finished its window
frame_err  out  1  one-cycle pulse: framing error, frame dropped

Behaviour:
- Reset (rst=1 at posedge):
  - Loader -> FILL, wr_idx=0, s_ready=1.
  - Presenter -> IDLE, frame_valid=0, step_idx=0.
  - frame_done=0, frame_err=0; all pixel_value and shadow entries = 0.
  - A partially loaded frame is discarded.
  - Reset overrides every other event in the same cycle.
- Handshake: a pixel is accepted on a posedge with s_valid && s_ready. s_ready is registered and depends only on loader state (FILL=1, FULL=0), never on s_valid.
- Loader FSM:
  - FILL:
    - An accepted pixel writes shadow[wr_idx].
    - If wr_idx==INPUT_SIZE-1 and s_last=1: -> FULL, wr_idx=0.
    - If s_last differs from (wr_idx==INPUT_SIZE-1), in either direction: frame_err=1 next cycle, wr_idx=0, stay in FILL, partial shadow contents ignored.
    - Otherwise wr_idx+=1.
  - FULL: s_ready=0. -> FILL on a swap.
- Swap condition, evaluated each cycle: loader==FULL && (presenter==IDLE || final_tick).
  - final_tick = presenter==RUN && step_tick && step_idx==NUM_TIMESTEPS-1.
  - On a swap edge: pixel_value <= shadow (all entries), step_idx<=0, presenter=RUN, frame_valid=1, loader=FILL, s_ready=1.
- Presenter FSM:
  - IDLE: frame_valid=0, pixel_value all 0, step_tick ignored.
  - RUN: each step_tick increments step_idx. On final_tick, frame_done=1 for one cycle. Then either swap (back-to-back frames, frame_valid stays 1, no gap) or -> IDLE with pixel_value cleared to 0 and step_idx=0.
- Latency: last pixel accepted at edge E0 -> loader FULL after E0 -> swap at E1 (if presenter is idle) -> frame_valid=1 and new pixel_value visible after E1 (2 cycles). s_ready is 0 for exactly one cycle in that case.
- Back-pressure: a frame stays in the shadow (s_ready=0) until the current window completes. Throughput is bounded by NUM_TIMESTEPS step_ticks per frame.
- pixel_value is stable for the whole RUN window. It changes only on a swap or on RUN->IDLE.
- step_tick coinciding with a swap-from-IDLE edge is ignored: the new frame's count starts at 0.
- step_idx never exceeds NUM_TIMESTEPS-1 while in RUN.
- Storage: 2 x INPUT_SIZE x PIXEL_WIDTH flops. No arithmetic beyond the index and step counters; counters never wrap silently.

Test Plan (INPUT_SIZE=4, NUM_TIMESTEPS=16):
- Reset, then stream {32,64,128,255} with s_last on the 4th pixel, step_tick every 25 cycles -> frame_valid rises 2 cycles after the last handshake; pixel_value={32,64,128,255}; frame_done pulses once after the 16th tick; then IDLE with pixel_value={0,0,0,0}.
- Second frame {10,120,200,250} streamed during frame 1 -> s_ready=0 after its last pixel until the 16th tick of frame 1; swap on that edge; frame_valid stays 1; step_idx restarts at 0.
- s_last asserted on the 3rd pixel, then 3rd-pixel-of-4 with s_last=0 followed by a 4th with s_last=0 -> first case: frame_err pulse after pixel 3, wr_idx=0, no frame_valid; second case: frame_err after pixel 4; a following correct frame {255,255,255,255} loads normally.
- s_valid toggled randomly (50%) during a load -> only handshaken pixels are stored; contents match the sent sequence in order.
- rst pulsed mid-load (after 2 pixels) and mid-RUN (step_idx=7) -> all outputs return to reset values the next cycle; the next full frame loads from index 0.
- step_tick held high continuously -> frame presented for exactly 16 cycles; frame_done on the 16th; no extra increments while IDLE.

Source files
------------

// File: rtl/pixel_frame_loader.sv
// Double-buffered frame loader: assembles a serial pixel stream into a shadow
// buffer and presents the previous frame in parallel for a fixed number of timesteps.
module pixel_frame_loader #(
  parameter int INPUT_SIZE    = 784,
  parameter int PIXEL_WIDTH   = 8,
  parameter int NUM_TIMESTEPS = 16,
  parameter int IDX_W         = $clog2(INPUT_SIZE),
  parameter int STEP_W        = $clog2(NUM_TIMESTEPS + 1)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    s_valid,
  output logic                                    s_ready,
  input  logic [PIXEL_WIDTH-1:0]                  s_data,
  input  logic                                    s_last,
  input  logic                                    step_tick,
  output logic [INPUT_SIZE-1:0][PIXEL_WIDTH-1:0]  pixel_value,
  output logic                                    frame_valid,
  output logic [STEP_W-1:0]                       step_idx,
  output logic                                    frame_done,
  output logic                                    frame_err
);

  typedef enum logic {FILL, FULL} load_t;
  typedef enum logic {IDLE, RUN}  pres_t;

  load_t load_st, load_nx;
  pres_t pres_st, pres_nx;

  logic [IDX_W-1:0]                       wr_idx, wr_idx_nx;
  logic [STEP_W-1:0]                      step_nx;
  logic [INPUT_SIZE-1:0][PIXEL_WIDTH-1:0] shadow;
  logic                                   err_nx, done_nx, load_pix, clear_pix;
  logic                                   accept, at_end, final_tick, swap;

  assign s_ready     = (load_st == FILL);
  assign frame_valid = (pres_st == RUN);
  assign accept      = s_valid && s_ready;
  assign at_end      = (wr_idx == IDX_W'(INPUT_SIZE - 1));
  assign final_tick  = (pres_st == RUN) && step_tick && (step_idx == STEP_W'(NUM_TIMESTEPS - 1));
  assign swap        = (load_st == FULL) && ((pres_st == IDLE) || final_tick);

  always_comb begin
    load_nx   = load_st;
    wr_idx_nx = wr_idx;
    err_nx    = 1'b0;
    pres_nx   = pres_st;
    step_nx   = step_idx;
    done_nx   = final_tick;
    load_pix  = 1'b0;
    clear_pix = 1'b0;

    case (load_st)
      FILL: begin
        if (accept) begin
          // A frame must end exactly on its last index; anything else drops it.
          if (s_last != at_end) begin
            err_nx    = 1'b1;
            wr_idx_nx = '0;
          end else if (at_end) begin
            load_nx   = FULL;
            wr_idx_nx = '0;
          end else begin
            wr_idx_nx = wr_idx + IDX_W'(1);
          end
        end
      end
      FULL: begin
        if (swap) load_nx = FILL;
      end
      default: load_nx = FILL;
    endcase

    // A swap takes priority; a tick on a swap-from-idle edge is dropped.
    if (swap) begin
      pres_nx  = RUN;
      step_nx  = '0;
      load_pix = 1'b1;
    end else if (pres_st == RUN && step_tick) begin
      if (final_tick) begin
        pres_nx   = IDLE;
        step_nx   = '0;
        clear_pix = 1'b1;
      end else begin
        step_nx = step_idx + STEP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_st     <= FILL;
      pres_st     <= IDLE;
      wr_idx      <= '0;
      step_idx    <= '0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      shadow      <= '0;
      pixel_value <= '0;
    end else begin
      load_st    <= load_nx;
      pres_st    <= pres_nx;
      wr_idx     <= wr_idx_nx;
      step_idx   <= step_nx;
      frame_done <= done_nx;
      frame_err  <= err_nx;
      if (accept) shadow[wr_idx] <= s_data;
      if (load_pix)       pixel_value <= shadow;
      else if (clear_pix) pixel_value <= '0;
    end
  end

endmodule

// File: tb/tb_pixel_frame_loader.sv
// Randomized bench for pixel_frame_loader, compared cycle by cycle against a
// queue-based frame/window model plus scenario-specific expectations.
module tb_pixel_frame_loader;
  localparam int IS = 4;
  localparam int NT = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 s_valid = 1'b0;
  logic                 s_ready;
  logic [7:0]           s_data = 8'd0;
  logic                 s_last = 1'b0;
  logic                 step_tick = 1'b0;
  logic [IS-1:0][7:0]   pixel_value;
  logic                 frame_valid;
  logic [4:0]           step_idx;
  logic                 frame_done;
  logic                 frame_err;

  pixel_frame_loader #(.INPUT_SIZE(IS), .PIXEL_WIDTH(8), .NUM_TIMESTEPS(NT)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .step_tick(step_tick), .pixel_value(pixel_value),
    .frame_valid(frame_valid), .step_idx(step_idx), .frame_done(frame_done),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: collected pixels, one pending frame, one presented window.
  logic [7:0]         col[$];
  logic [IS-1:0][7:0] m_pend = '0;
  logic [IS-1:0][7:0] m_act = '0;
  logic               m_has_pend = 1'b0;
  logic               m_run = 1'b0;
  logic [4:0]         m_ticks = 5'd0;
  logic               m_done = 1'b0;
  logic               m_err = 1'b0;
  logic               m_fin, m_old_pend;

  always @(posedge clk) begin
    if (rst) begin
      col.delete();
      m_has_pend = 1'b0; m_run = 1'b0; m_ticks = 5'd0;
      m_act = '0; m_pend = '0; m_done = 1'b0; m_err = 1'b0;
    end else begin
      m_fin      = m_run && step_tick && (m_ticks == 5'(NT - 1));
      m_old_pend = m_has_pend;
      m_done     = m_fin;
      m_err      = 1'b0;
      if (m_has_pend && (!m_run || m_fin)) begin
        m_act = m_pend; m_run = 1'b1; m_ticks = 5'd0; m_has_pend = 1'b0;
      end else if (m_run && step_tick) begin
        if (m_fin) begin m_run = 1'b0; m_ticks = 5'd0; m_act = '0; end
        else m_ticks = m_ticks + 5'd1;
      end
      if (!m_old_pend && s_valid) begin
        col.push_back(s_data);
        if (s_last != (col.size() == IS)) begin
          m_err = 1'b1; col.delete();
        end else if (s_last) begin
          for (int i = 0; i < IS; i++) m_pend[i] = col[i];
          m_has_pend = 1'b1; col.delete();
        end
      end
    end
  end

  wire [40:0] obs  = {s_ready, frame_valid, step_idx, frame_done, frame_err, pixel_value};
  wire [40:0] expv = {~m_has_pend, m_run, m_ticks, m_done, m_err, m_act};

  // Stimulus driver: {last,data} queue, step_tick period, handshake retirement.
  logic [8:0] tx[$];
  logic       rdy_seen = 1'b1;
  int         tick_per = 0;
  int         cyc = 0;

  task automatic drive(input bit rnd);
    if (s_valid && rdy_seen) void'(tx.pop_front());
    cyc++;
    step_tick = (tick_per != 0) && (cyc % tick_per == 0);
    if (tx.size() > 0 && (!rnd || $urandom_range(1, 0) == 1)) begin
      s_valid = 1'b1; s_data = tx[0][7:0]; s_last = tx[0][8];
    end else begin
      s_valid = 1'b0; s_data = 8'($urandom); s_last = 1'($urandom);
    end
    rdy_seen = s_ready;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; step_tick = 1'b0; tx.delete();
    repeat (2) begin
      @(negedge clk); n_cmp++;
      if (obs !== expv) begin n_fail++; $display("FAIL reset_model got=%h exp=%h", obs, expv); end
    end
    n_cmp++;
    if ({s_ready, frame_valid, step_idx, frame_done, frame_err} !== 9'b1_0_00000_0_0 || pixel_value !== '0) begin
      n_fail++; $display("FAIL reset_values got=%h", obs);
    end
    rst = 1'b0;
    rdy_seen = s_ready;
  endtask

  task automatic test_basic_frame();
    int last_cyc = -1, valid_cyc = -1, dones = 0;
    logic [IS-1:0][7:0] pix_at_valid = '0;
    tick_per = 25;
    tx.push_back(9'h020); tx.push_back(9'h040); tx.push_back(9'h080); tx.push_back(9'h1FF);
    for (int c = 0; c < 460; c++) begin
      @(negedge clk); n_cmp++;
      if (obs !== expv) begin n_fail++; $display("FAIL basic cyc=%0d got=%h exp=%h", cyc, obs, expv); end
      if (s_valid && rdy_seen && s_last) last_cyc = cyc;
      if (frame_valid && valid_cyc < 0) begin valid_cyc = cyc; pix_at_valid = pixel_value; end
      if (frame_done) dones++;
      drive(0);
    end
    // frame_valid shows one sample after the edge that took the last pixel
    n_cmp++;
    if (valid_cyc - last_cyc != 1) begin n_fail++; $display("FAIL basic_latency got=%0d exp=1", valid_cyc - last_cyc); end
    n_cmp++;
    if (pix_at_valid !== {8'd255, 8'd128, 8'd64, 8'd32}) begin n_fail++; $display("FAIL basic_pixels got=%h", pix_at_valid); end
    n_cmp++;
    if (dones != 1) begin n_fail++; $display("FAIL basic_done_count got=%0d exp=1", dones); end
    n_cmp++;
    if (frame_valid !== 1'b0 || pixel_value !== '0) begin n_fail++; $display("FAIL basic_idle got=%b/%h exp=0/0", frame_valid, pixel_value); end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    bit seen_valid = 0, gap = 0;
    tick_per = 25;
    for (int i = 0; i < IS; i++) tx.push_back({1'(i == IS - 1), 8'($urandom)});
    tx.push_back(9'h00A); tx.push_back(9'h078); tx.push_back(9'h0C8); tx.push_back(9'h1FA);
    for (int c = 0; c < 1000 && dones < 2; c++) begin
      @(negedge clk); n_cmp++;
      if (obs !== expv) begin n_fail++; $display("FAIL b2b cyc=%0d got=%h exp=%h", cyc, obs, expv); end
      if (frame_valid) seen_valid = 1;
      if (frame_done) begin
        dones++;
        if (dones == 1) begin
          n_cmp++;
          if (frame_valid !== 1'b1 || step_idx !== 5'd0 || pixel_value !== {8'd250, 8'd200, 8'd120, 8'd10}) begin
            n_fail++; $display("FAIL b2b_swap got=%b/%0d/%h", frame_valid, step_idx, pixel_value);
          end
        end
      end
      if (seen_valid && dones < 2 && !frame_valid) gap = 1;
      drive(0);
    end
    n_cmp++;
    if (dones != 2) begin n_fail++; $display("FAIL b2b_done_count got=%0d exp=2", dones); end
    n_cmp++;
    if (gap) begin n_fail++; $display("FAIL b2b_gap got=1 exp=0"); end
  endtask

  task automatic test_framing_errors();
    int errs = 0;
    tick_per = 0;
    tx.push_back(9'h001); tx.push_back(9'h002); tx.push_back(9'h103);
    tx.push_back(9'h004); tx.push_back(9'h005); tx.push_back(9'h006); tx.push_back(9'h007);
    tx.push_back(9'h0FF); tx.push_back(9'h0FF); tx.push_back(9'h0FF); tx.push_back(9'h1FF);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); n_cmp++;
      if (obs !== expv) begin n_fail++; $display("FAIL framing cyc=%0d got=%h exp=%h", cyc, obs, expv); end
      if (frame_err) errs++;
      drive(0);
    end
    n_cmp++;
    if (errs != 2) begin n_fail++; $display("FAIL framing_err_count got=%0d exp=2", errs); end
    n_cmp++;
    if (frame_valid !== 1'b1 || pixel_value !== {IS{8'hFF}}) begin
      n_fail++; $display("FAIL framing_recover got=%b/%h exp=1/ffffffff", frame_valid, pixel_value);
    end
  endtask

  task automatic test_step_held();
    int done_at = -1, dones = 0;
    tick_per = 1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); n_cmp++;
      if (obs !== expv) begin n_fail++; $display("FAIL held cyc=%0d got=%h exp=%h", cyc, obs, expv); end
      if (frame_done) begin dones++; if (done_at < 0) done_at = c; end
      drive(0);
    end
    n_cmp++;
    if (done_at != NT || dones != 1) begin n_fail++; $display("FAIL held_window got=%0d/%0d exp=%0d/1", done_at, dones, NT); end
    n_cmp++;
    if (frame_valid !== 1'b0 || step_idx !== 5'd0) begin n_fail++; $display("FAIL held_idle got=%b/%0d exp=0/0", frame_valid, step_idx); end
  endtask

  task automatic test_random_valid();
    logic [IS-1:0][7:0] fr;
    bit ok = 0;
    tick_per = 0;
    for (int i = 0; i < IS; i++) begin fr[i] = 8'($urandom); tx.push_back({1'(i == IS - 1), fr[i]}); end
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk); n_cmp++;
      if (obs !== expv) begin n_fail++; $display("FAIL rndvalid cyc=%0d got=%h exp=%h", cyc, obs, expv); end
      if (frame_valid) ok = 1;
      else drive(1);
    end
    n_cmp++;
    if (!ok || pixel_value !== fr) begin n_fail++; $display("FAIL rndvalid_pixels got=%h exp=%h", pixel_value, fr); end
    drive(0);
  endtask

  task automatic test_reset_mid();
    logic [IS-1:0][7:0] fr;
    bit hit = 0, ok = 0;
    tick_per = 1;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk); n_cmp++;
      if (obs !== expv) begin n_fail++; $display("FAIL midrun cyc=%0d got=%h exp=%h", cyc, obs, expv); end
      if (frame_valid && step_idx == 5'd7) hit = 1;
      else drive(0);
    end
    rst = 1'b1;
    @(negedge clk); n_cmp++;
    if (!hit || {s_ready, frame_valid, step_idx, frame_done, frame_err} !== 9'b1_0_00000_0_0 || pixel_value !== '0) begin
      n_fail++; $display("FAIL midrun_reset hit=%0d got=%h", hit, obs);
    end
    rst = 1'b0; tick_per = 0; s_valid = 1'b0; rdy_seen = s_ready;
    tx.push_back(9'h0AA); tx.push_back(9'h0BB);
    for (int c = 0; c < 20 && tx.size() > 0; c++) begin
      @(negedge clk); drive(0);
    end
    rst = 1'b1;
    @(negedge clk); n_cmp++;
    if ({s_ready, frame_valid, step_idx, frame_done, frame_err} !== 9'b1_0_00000_0_0 || obs !== expv) begin
      n_fail++; $display("FAIL midload_reset got=%h exp=%h", obs, expv);
    end
    rst = 1'b0; s_valid = 1'b0; rdy_seen = s_ready;
    for (int i = 0; i < IS; i++) begin fr[i] = 8'($urandom); tx.push_back({1'(i == IS - 1), fr[i]}); end
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk); n_cmp++;
      if (obs !== expv) begin n_fail++; $display("FAIL midload cyc=%0d got=%h exp=%h", cyc, obs, expv); end
      if (frame_valid) ok = 1;
      else drive(0);
    end
    n_cmp++;
    if (!ok || pixel_value !== fr) begin n_fail++; $display("FAIL midload_pixels got=%h exp=%h", pixel_value, fr); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_framing_errors();
    test_step_held();
    test_random_valid();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end
endmodule
